// File: rtl/alu_op_pkg.sv
// Shared select-code definitions for the ALU operand stage.
// Codes are grouped by source (A/B/R) and by transform (pass/negate/invert).
package alu_op_pkg;

  localparam logic [3:0] OP_ZERO  = 4'b0000;
  localparam logic [3:0] OP_A     = 4'b0001;
  localparam logic [3:0] OP_B     = 4'b0010;
  localparam logic [3:0] OP_R     = 4'b0011;
  localparam logic [3:0] OP_NEG_A = 4'b0100;
  localparam logic [3:0] OP_NEG_B = 4'b0101;
  localparam logic [3:0] OP_NEG_R = 4'b0111;
  localparam logic [3:0] OP_NOT_A = 4'b1001;
  localparam logic [3:0] OP_NOT_B = 4'b1010;
  localparam logic [3:0] OP_NOT_R = 4'b1011;

  function automatic logic is_legal_op(input logic [3:0] sel);
    case (sel)
      OP_ZERO, OP_A, OP_B, OP_R,
      OP_NEG_A, OP_NEG_B, OP_NEG_R,
      OP_NOT_A, OP_NOT_B, OP_NOT_R: return 1'b1;
      default:                      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_operand_stage_if.sv
// Operand-stage bus: upstream valid/ready request plus downstream valid/ready result.
// The master side drives operands and out_ready; the slave side is the stage itself.
interface alu_operand_stage_if #(
  parameter int WIDTH = 6
);
  logic                    in_valid;
  logic                    in_ready;
  logic [3:0]              sel;
  logic signed [WIDTH-1:0] a;
  logic signed [WIDTH-1:0] b;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] x;
  logic                    ovf;
  logic                    illegal;

  modport master (
    output in_valid, sel, a, b, out_ready,
    input  in_ready, out_valid, x, ovf, illegal
  );

  modport slave (
    input  in_valid, sel, a, b, out_ready,
    output in_ready, out_valid, x, ovf, illegal
  );
endinterface

// File: rtl/alu_operand_core.sv
// Combinational operand selector: pass, negate, invert or zero of A, B or the feedback value R.
// Illegal codes are fully decoded so no latch can form.
module alu_operand_core
  import alu_op_pkg::*;
#(
  parameter int WIDTH        = 6,
  parameter bit ILLEGAL_ZERO = 1'b1
) (
  input  logic [3:0]              sel,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic signed [WIDTH-1:0] r,
  output logic signed [WIDTH-1:0] x,
  output logic                    ovf,
  output logic                    illegal
);

  localparam logic signed [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic signed [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  // Two's-complement negate; the most-negative value maps onto itself.
  function automatic logic signed [WIDTH-1:0] negate(input logic signed [WIDTH-1:0] v);
    return ~v + ONE;
  endfunction

  function automatic logic neg_ovf(input logic signed [WIDTH-1:0] v);
    return v == MOST_NEG;
  endfunction

  always_comb begin
    x       = '0;
    ovf     = 1'b0;
    illegal = 1'b0;
    case (sel)
      OP_ZERO:  x = '0;
      OP_A:     x = a;
      OP_B:     x = b;
      OP_R:     x = r;
      OP_NEG_A: begin x = negate(a); ovf = neg_ovf(a); end
      OP_NEG_B: begin x = negate(b); ovf = neg_ovf(b); end
      OP_NEG_R: begin x = negate(r); ovf = neg_ovf(r); end
      OP_NOT_A: x = ~a;
      OP_NOT_B: x = ~b;
      OP_NOT_R: x = ~r;
      default: begin
        illegal = 1'b1;
        x       = ILLEGAL_ZERO ? '0 : a;
      end
    endcase
  end

endmodule

// File: rtl/alu_operand_stage.sv
// One-deep registered operand stage between register-file reads and the ALU adder.
// Holds the valid/ready handshake, the output register and the feedback register R.
module alu_operand_stage
  import alu_op_pkg::*;
#(
  parameter int WIDTH        = 6,
  parameter bit ILLEGAL_ZERO = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  alu_operand_stage_if.slave bus
);

  logic signed [WIDTH-1:0] x_p0;
  logic                    ovf_p0;
  logic                    illegal_p0;
  logic                    accept_p0;

  logic signed [WIDTH-1:0] x_p1;
  logic                    ovf_p1;
  logic                    illegal_p1;
  logic                    vld_p1;
  logic signed [WIDTH-1:0] r_p1;

  alu_operand_core #(
    .WIDTH        (WIDTH),
    .ILLEGAL_ZERO (ILLEGAL_ZERO)
  ) u_core (
    .sel     (bus.sel),
    .a       (bus.a),
    .b       (bus.b),
    .r       (r_p1),
    .x       (x_p0),
    .ovf     (ovf_p0),
    .illegal (illegal_p0)
  );

  // A consume and a new accept can share a cycle, so a single register never bubbles.
  assign bus.in_ready = !vld_p1 || bus.out_ready;
  assign accept_p0    = bus.in_valid && bus.in_ready;

  // p0 -> p1: output register and feedback register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      x_p1       <= '0;
      ovf_p1     <= 1'b0;
      illegal_p1 <= 1'b0;
      r_p1       <= '0;
    end else if (accept_p0) begin
      vld_p1     <= 1'b1;
      x_p1       <= x_p0;
      ovf_p1     <= ovf_p0;
      illegal_p1 <= illegal_p0;
      if (!illegal_p0) r_p1 <= x_p0;
    end else if (bus.out_ready) begin
      vld_p1     <= 1'b0;
    end
  end

  assign bus.out_valid = vld_p1;
  assign bus.x         = x_p1;
  assign bus.ovf       = ovf_p1;
  assign bus.illegal   = illegal_p1;

endmodule
